// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST collar: FSM states, per-element operation table, background patterns.
package mbist_pkg;

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  typedef struct packed {
    logic down;
    logic rd_bg;
    logic wr_bg;
    logic has_rd;
    logic has_wr;
  } elem_t;

  // Backgrounds are built at this width and truncated by the user, so DATA_W must not exceed it.
  localparam int MAX_DATA_W = 1024;

  function automatic logic [MAX_DATA_W-1:0] bg_fill(input logic one);
    return {MAX_DATA_W{one}};
  endfunction

  function automatic logic elem_down(input state_t s);
    return (s == M3) || (s == M4);
  endfunction

  function automatic elem_t elem_info(input state_t s);
    elem_t e;
    e = '0;
    e.down = elem_down(s);
    case (s)
      M0: begin e.has_wr = 1'b1; e.wr_bg = 1'b0; end
      M1, M3: begin e.has_rd = 1'b1; e.rd_bg = 1'b0; e.has_wr = 1'b1; e.wr_bg = 1'b1; end
      M2, M4: begin e.has_rd = 1'b1; e.rd_bg = 1'b1; e.has_wr = 1'b1; e.wr_bg = 1'b0; end
      M5: begin e.has_rd = 1'b1; e.rd_bg = 1'b0; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] elem_index(input state_t s);
    case (s)
      M1: return 3'd1;
      M2: return 3'd2;
      M3: return 3'd3;
      M4: return 3'd4;
      M5: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// BIST address counter: loads the element start address, steps up or down, and wraps at DEPTH-1.
module mbist_addr_gen #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  assign last = down ? (addr == '0) : (addr == TOP);

  // Wrap uses the real depth so non power-of-two macros never see out-of-range addresses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP : '0;
    end else if (step) begin
      if (down) addr <= (addr == '0) ? TOP : addr - ADDR_W'(1);
      else      addr <= (addr == TOP) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sram_1w1r_mbist.sv
// March C- BIST collar for one 1W1R SRAM macro; muxes functional and test traffic onto the macro ports.
// Define MBIST_FAIL_LOG_EN to add first-failure address/element/data capture outputs.
module sram_1w1r_mbist
  import mbist_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 44,
  parameter int MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
`ifdef MBIST_FAIL_LOG_EN
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
  output logic [DATA_W-1:0] bist_fail_data,
`endif
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic              W0_en,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [DATA_W-1:0] R0_data,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic              mem_W0_en,
  output logic [MASK_W-1:0] mem_W0_mask,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [DATA_W-1:0] mem_R0_data
);

  localparam logic [DATA_W-1:0] BG0 = DATA_W'(bg_fill(1'b0));
  localparam logic [DATA_W-1:0] BG1 = DATA_W'(bg_fill(1'b1));

  state_t            state_q, state_d;
  elem_t             info;
  logic              phase_q, armed_q, done_q, fail_q;
  logic              start_go, in_elem, rw, op_done, elem_end;
  logic              last, step, load, load_down, bist_rd, bist_wr, miscompare;
  logic [ADDR_W-1:0] bist_addr;
  logic              exp_valid_q;
  logic [DATA_W-1:0] exp_data_q;

  assign info       = elem_info(state_q);
  assign in_elem    = state_q inside {M0, M1, M2, M3, M4, M5};
  assign bist_busy  = in_elem || (state_q == DRAIN);
  assign start_go   = ((state_q == IDLE) || (state_q == DONE)) && bist_start && armed_q;
  assign bist_done  = done_q;
  assign bist_fail  = fail_q;
  assign R0_data    = mem_R0_data;
  assign miscompare = exp_valid_q && (mem_R0_data != exp_data_q);

  mbist_addr_gen #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_down(load_down),
    .step     (step),
    .down     (info.down),
    .addr     (bist_addr),
    .last     (last)
  );

  // Read-then-write elements spend two cycles per address; phase_q selects the write half.
  always_comb begin
    rw        = info.has_rd && info.has_wr;
    op_done   = !rw || phase_q;
    bist_rd   = in_elem && info.has_rd && (!rw || !phase_q);
    bist_wr   = in_elem && info.has_wr && op_done;
    elem_end  = in_elem && op_done && last;
    step      = in_elem && op_done && !last;
    state_d   = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_go) state_d = M0;
      M0:         if (elem_end) state_d = M1;
      M1:         if (elem_end) state_d = M2;
      M2:         if (elem_end) state_d = M3;
      M3:         if (elem_end) state_d = M4;
      M4:         if (elem_end) state_d = M5;
      M5:         if (elem_end) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
    load      = start_go || elem_end;
    load_down = elem_down(state_d);
  end

  always_comb begin
    mem_W0_addr = W0_addr;
    mem_W0_data = W0_data;
    mem_W0_en   = W0_en;
    mem_W0_mask = W0_mask;
    mem_R0_addr = R0_addr;
    mem_R0_en   = R0_en;
    if (bist_busy) begin
      mem_W0_addr = bist_addr;
      mem_W0_data = info.wr_bg ? BG1 : BG0;
      mem_W0_en   = bist_wr;
      mem_W0_mask = '1;
      mem_R0_addr = bist_addr;
      mem_R0_en   = bist_rd;
    end
  end

  // Done lags DONE entry by one edge so the last drained compare is already in fail_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= rw && in_elem && !phase_q;
      if (start_go) armed_q <= 1'b0;
      else if (((state_q == IDLE) || (state_q == DONE)) && !bist_start) armed_q <= 1'b1;
      if (start_go) done_q <= 1'b0;
      else if (state_q == DONE) done_q <= 1'b1;
      if (start_go) fail_q <= 1'b0;
      else if (miscompare) fail_q <= 1'b1;
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] exp_addr_q;
  logic [2:0]        exp_elem_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
      exp_elem_q  <= '0;
    end else begin
      exp_valid_q <= bist_rd;
      exp_data_q  <= info.rd_bg ? BG1 : BG0;
      exp_addr_q  <= bist_addr;
      exp_elem_q  <= elem_index(state_q);
    end
  end

  // Only the first miscompare of a run is logged; later ones just keep fail sticky.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bist_fail_addr <= '0;
      bist_fail_elem <= '0;
      bist_fail_data <= '0;
    end else if (start_go) begin
      bist_fail_addr <= '0;
      bist_fail_elem <= '0;
      bist_fail_data <= '0;
    end else if (miscompare && !fail_q) begin
      bist_fail_addr <= exp_addr_q;
      bist_fail_elem <= exp_elem_q;
      bist_fail_data <= mem_R0_data;
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
    end else begin
      exp_valid_q <= bist_rd;
      exp_data_q  <= info.rd_bg ? BG1 : BG0;
    end
  end
`endif

endmodule

// File: tb/tb_sram_1w1r_mbist.sv
// Bench for sram_1w1r_mbist: behavioural 1W1R macros with injectable faults, a 128-word and a 27-word instance.
module tb_sram_1w1r_mbist;

  localparam int D  = 128;
  localparam int AW = 7;
  localparam int DW = 44;
  localparam int MW = 4;
  localparam int CW = DW / MW;
  localparam int DB = 27;
  localparam int AWB = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic          bist_start_a = 1'b0, bist_busy_a, bist_done_a, bist_fail_a;
  logic [AW-1:0] W0_addr_a = '0, R0_addr_a = '0, mem_W0_addr_a, mem_R0_addr_a;
  logic [DW-1:0] W0_data_a = '0, R0_data_a, mem_W0_data_a, mem_R0_data_a;
  logic          W0_en_a = 1'b0, R0_en_a = 1'b0, mem_W0_en_a, mem_R0_en_a;
  logic [MW-1:0] W0_mask_a = '0, mem_W0_mask_a;

  logic           bist_start_b = 1'b0, bist_busy_b, bist_done_b, bist_fail_b;
  logic [AWB-1:0] W0_addr_b = '0, R0_addr_b = '0, mem_W0_addr_b, mem_R0_addr_b;
  logic [DW-1:0]  W0_data_b = '0, R0_data_b, mem_W0_data_b, mem_R0_data_b;
  logic           W0_en_b = 1'b0, R0_en_b = 1'b0, mem_W0_en_b, mem_R0_en_b;
  logic [0:0]     W0_mask_b = '0, mem_W0_mask_b;

`ifdef MBIST_FAIL_LOG_EN
  logic [AW-1:0]  fail_addr_a;
  logic [2:0]     fail_elem_a;
  logic [DW-1:0]  fail_data_a;
  logic [AWB-1:0] fail_addr_b;
  logic [2:0]     fail_elem_b;
  logic [DW-1:0]  fail_data_b;
`endif

  sram_1w1r_mbist #(.DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut_a (
    .clock(clock), .reset(reset), .bist_start(bist_start_a),
    .bist_busy(bist_busy_a), .bist_done(bist_done_a), .bist_fail(bist_fail_a),
`ifdef MBIST_FAIL_LOG_EN
    .bist_fail_addr(fail_addr_a), .bist_fail_elem(fail_elem_a), .bist_fail_data(fail_data_a),
`endif
    .W0_addr(W0_addr_a), .W0_data(W0_data_a), .W0_en(W0_en_a), .W0_mask(W0_mask_a),
    .R0_addr(R0_addr_a), .R0_en(R0_en_a), .R0_data(R0_data_a),
    .mem_W0_addr(mem_W0_addr_a), .mem_W0_data(mem_W0_data_a), .mem_W0_en(mem_W0_en_a),
    .mem_W0_mask(mem_W0_mask_a), .mem_R0_addr(mem_R0_addr_a), .mem_R0_en(mem_R0_en_a),
    .mem_R0_data(mem_R0_data_a)
  );

  sram_1w1r_mbist #(.DEPTH(DB), .ADDR_W(AWB), .DATA_W(DW), .MASK_W(1)) dut_b (
    .clock(clock), .reset(reset), .bist_start(bist_start_b),
    .bist_busy(bist_busy_b), .bist_done(bist_done_b), .bist_fail(bist_fail_b),
`ifdef MBIST_FAIL_LOG_EN
    .bist_fail_addr(fail_addr_b), .bist_fail_elem(fail_elem_b), .bist_fail_data(fail_data_b),
`endif
    .W0_addr(W0_addr_b), .W0_data(W0_data_b), .W0_en(W0_en_b), .W0_mask(W0_mask_b),
    .R0_addr(R0_addr_b), .R0_en(R0_en_b), .R0_data(R0_data_b),
    .mem_W0_addr(mem_W0_addr_b), .mem_W0_data(mem_W0_data_b), .mem_W0_en(mem_W0_en_b),
    .mem_W0_mask(mem_W0_mask_b), .mem_R0_addr(mem_R0_addr_b), .mem_R0_en(mem_R0_en_b),
    .mem_R0_data(mem_R0_data_b)
  );

  // Behavioural macros: read data lands one cycle after the read enable, read sees pre-write contents.
  logic [DW-1:0] mem_a [D];
  logic [DW-1:0] mem_b [DB];
  logic [DW-1:0] rdata_a, rdata_b;
  logic sa_en = 1'b0;
  logic cf_en = 1'b0;
  int rd_cnt_a = 0, wr_cnt_a = 0, leak_a = 0, range_err_b = 0;

  assign mem_R0_data_a = rdata_a;
  assign mem_R0_data_b = rdata_b;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [MW-1:0] mask, input logic stuck);
    logic [DW-1:0] w;
    w = old;
    for (int c = 0; c < MW; c++)
      if (mask[c]) w[c*CW +: CW] = data[c*CW +: CW];
    if (stuck) w[5] = 1'b0;
    return w;
  endfunction

  always @(posedge clock) begin
    if (mem_R0_en_a) rdata_a <= mem_a[mem_R0_addr_a];
    if (mem_W0_en_a) begin
      mem_a[mem_W0_addr_a] <= merge(mem_a[mem_W0_addr_a], mem_W0_data_a, mem_W0_mask_a,
                                    sa_en && (mem_W0_addr_a == AW'(37)));
      if (cf_en && (mem_W0_addr_a == AW'(10))) mem_a[11][0] <= ~mem_a[11][0];
    end
    if (bist_busy_a && mem_R0_en_a) rd_cnt_a <= rd_cnt_a + 1;
    if (bist_busy_a && mem_W0_en_a) wr_cnt_a <= wr_cnt_a + 1;
    if (bist_busy_a && mem_W0_en_a &&
        (((mem_W0_data_a != '0) && (mem_W0_data_a != '1)) || (mem_W0_mask_a != '1)))
      leak_a <= leak_a + 1;
  end

  always @(posedge clock) begin
    if (mem_R0_en_b && (int'(mem_R0_addr_b) < DB)) rdata_b <= mem_b[mem_R0_addr_b];
    if (mem_W0_en_b && (int'(mem_W0_addr_b) < DB)) mem_b[mem_W0_addr_b] <= mem_W0_data_b;
    if ((mem_R0_en_b && (int'(mem_R0_addr_b) >= DB)) || (mem_W0_en_b && (int'(mem_W0_addr_b) >= DB)))
      range_err_b <= range_err_b + 1;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? bist_busy_b : bist_busy_a;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? bist_done_b : bist_done_a;
  endfunction

  function automatic logic fail_of(input bit sel);
    return sel ? bist_fail_b : bist_fail_a;
  endfunction

  // One full BIST run; optional functional traffic on dut_a while the collar owns the macro.
  task automatic apply_stimulus(input bit sel, input int exp_edges, input bit traffic, input string tag);
    int edges, gaps, rd0, wr0, lk0;
    edges = 0;
    gaps  = 0;
    @(negedge clock);
    if (sel) bist_start_b = 1'b1;
    else bist_start_a = 1'b1;
    rd0 = rd_cnt_a;
    wr0 = wr_cnt_a;
    lk0 = leak_a;
    @(posedge clock);
    #1;
    bist_start_a = 1'b0;
    bist_start_b = 1'b0;
    if (traffic) begin
      W0_en_a = 1'b1; W0_addr_a = AW'(5); W0_data_a = 44'hDEADBEEF123; W0_mask_a = '1;
      R0_en_a = 1'b1; R0_addr_a = AW'(99);
    end
    check_output({tag, "_busy_on"}, 64'(busy_of(sel)), 64'd1);
    check_output({tag, "_done_clr"}, 64'(done_of(sel)), 64'd0);
    check_output({tag, "_fail_clr"}, 64'(fail_of(sel)), 64'd0);
`ifdef MBIST_FAIL_LOG_EN
    if (!sel) check_output({tag, "_log_clr"}, 64'(fail_addr_a), 64'd0);
`endif
    while (!done_of(sel) && (edges < 20000)) begin
      @(posedge clock);
      edges++;
      #1;
      if ((edges <= exp_edges - 2) && !busy_of(sel)) gaps++;
      if (edges == exp_edges - 10) begin
        W0_en_a = 1'b0;
        R0_en_a = 1'b0;
      end
    end
    check_output({tag, "_done_edges"}, 64'(edges), 64'(exp_edges));
    check_output({tag, "_busy_gaps"}, 64'(gaps), 64'd0);
    if (!sel) begin
      check_output({tag, "_bist_reads"}, 64'(rd_cnt_a - rd0), 64'(5 * D));
      check_output({tag, "_bist_writes"}, 64'(wr_cnt_a - wr0), 64'(5 * D));
      check_output({tag, "_func_leak"}, 64'(leak_a - lk0), 64'd0);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [DW-1:0] sb[$];

  initial begin
    vecs[0] = '{1'b0, 7'd5,   44'h0,           4'h0,    44'h0};
    vecs[1] = '{1'b1, 7'd3,   44'h123456789AB, 4'hF,    44'h0};
    vecs[2] = '{1'b0, 7'd3,   44'h0,           4'h0,    44'h123456789AB};
    vecs[3] = '{1'b1, 7'd20,  44'hFFFFFFFFFFF, 4'b0101, 44'h0};
    vecs[4] = '{1'b0, 7'd20,  44'h0,           4'h0,    44'h001FFC007FF};
    vecs[5] = '{1'b1, 7'd127, 44'hA5A5A5A5A5A, 4'hF,    44'h0};
    vecs[6] = '{1'b0, 7'd127, 44'h0,           4'h0,    44'hA5A5A5A5A5A};
    vecs[7] = '{1'b0, 7'd0,   44'h0,           4'h0,    44'h0};

    repeat (3) @(posedge clock);
    #1;
    check_output("rst_busy", 64'(bist_busy_a), 64'd0);
    check_output("rst_done", 64'(bist_done_a), 64'd0);
    check_output("rst_fail", 64'(bist_fail_a), 64'd0);
    check_output("rst_mem_wen", 64'(mem_W0_en_a), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] fault-free run with functional traffic during busy");
    apply_stimulus(1'b0, 10 * D + 2, 1'b1, "clean");
    check_output("clean_fail", 64'(bist_fail_a), 64'd0);

    $display("[TB] functional table after BIST");
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      W0_en_a   = vecs[i].wr;
      W0_addr_a = vecs[i].addr;
      W0_data_a = vecs[i].data;
      W0_mask_a = vecs[i].mask;
      R0_en_a   = !vecs[i].wr;
      R0_addr_a = vecs[i].addr;
      if (!vecs[i].wr) sb.push_back(vecs[i].exp);
      #1;
      check_output($sformatf("vec%0d_pass_wen", i), 64'(mem_W0_en_a), 64'(vecs[i].wr));
      check_output($sformatf("vec%0d_pass_addr", i),
                   64'(vecs[i].wr ? mem_W0_addr_a : mem_R0_addr_a), 64'(vecs[i].addr));
      @(posedge clock);
      #1;
      W0_en_a = 1'b0;
      R0_en_a = 1'b0;
      if (sb.size() > 0) check_output($sformatf("vec%0d_rdata", i), 64'(R0_data_a), 64'(sb.pop_front()));
    end

    $display("[TB] stuck-at-0 bit 5 at addr 37");
    sa_en = 1'b1;
    apply_stimulus(1'b0, 10 * D + 2, 1'b0, "sa0");
    check_output("sa0_fail", 64'(bist_fail_a), 64'd1);
`ifdef MBIST_FAIL_LOG_EN
    check_output("sa0_log_addr", 64'(fail_addr_a), 64'd37);
    check_output("sa0_log_elem", 64'(fail_elem_a), 64'd2);
    check_output("sa0_log_data", 64'(fail_data_a), 64'hFFFFFFFFFDF);
`endif
    sa_en = 1'b0;

    $display("[TB] coupling fault addr 10 -> addr 11");
    cf_en = 1'b1;
    apply_stimulus(1'b0, 10 * D + 2, 1'b0, "cf");
    check_output("cf_fail", 64'(bist_fail_a), 64'd1);
`ifdef MBIST_FAIL_LOG_EN
    check_output("cf_log_addr", 64'(fail_addr_a), 64'd11);
    check_output("cf_log_elem", 64'(fail_elem_a), 64'd1);
    check_output("cf_log_data", 64'(fail_data_a), 64'h1);
`endif
    cf_en = 1'b0;

    $display("[TB] reset during M3");
    sa_en = 1'b1;
    @(negedge clock);
    bist_start_a = 1'b1;
    @(posedge clock);
    #1;
    bist_start_a = 1'b0;
    repeat (700) @(posedge clock);
    #1;
    check_output("m3_busy_before", 64'(bist_busy_a), 64'd1);
    check_output("m3_fail_before", 64'(bist_fail_a), 64'd1);
    reset = 1'b1;
    #1;
    check_output("m3_rst_busy", 64'(bist_busy_a), 64'd0);
    check_output("m3_rst_done", 64'(bist_done_a), 64'd0);
    check_output("m3_rst_fail", 64'(bist_fail_a), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    sa_en = 1'b0;
    apply_stimulus(1'b0, 10 * D + 2, 1'b0, "restart");
    check_output("restart_fail", 64'(bist_fail_a), 64'd0);

    $display("[TB] 27-word macro");
    apply_stimulus(1'b1, 10 * DB + 2, 1'b0, "d27");
    check_output("d27_fail", 64'(bist_fail_b), 64'd0);
    check_output("d27_addr_range", 64'(range_err_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
